result_bcd_converter: RTL and testbench

- Sequential double-dabble converter sitting directly downstream of the operand/result buffer stage.
- Takes the 9-bit unsigned magnitude plus sign of the value currently on display and produces sign + three BCD digits with leading-zero blank flags.
- Its outputs feed the seven-segment decoders.
- Performs one shift per clock under a start/done handshake, so no wide combinational divider is needed.

---
 rtl/result_bcd_converter.sv | 96 +++++++++
 tb/tb_result_bcd_converter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble: magnitude + sign in, sign + three BCD digits with
// leading-zero blank flags out, one shift per clock under a start/done handshake.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   SHIFT | add-3 correction then one left shift per cycle, WIDTH cycles
//   DONE  | scratch copied to the digit outputs, done pulses next cycle
module result_bcd_converter #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [WIDTH-1:0] mag,
    input  logic             sign_in,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             sign_out,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             blank_h,
    output logic             blank_t
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [11:0]      scratch;
    logic [11:0]      adj;
    logic [3:0]       cnt;
    logic             sign_lat;

    always_comb begin
        adj = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            sign_lat <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            sign_out <= 1'b0;
            hundreds <= '0;
            tens     <= '0;
            ones     <= '0;
            blank_h  <= 1'b0;
            blank_t  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= mag;
                        // a zero magnitude never displays as negative
                        sign_lat <= sign_in & (|mag);
                        scratch  <= '0;
                        cnt      <= 4'(WIDTH);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= {adj[10:0], shreg[WIDTH-1]};
                    shreg   <= shreg << 1;
                    cnt     <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                DONE: begin
                    hundreds <= scratch[11:8];
                    tens     <= scratch[7:4];
                    ones     <= scratch[3:0];
                    sign_out <= sign_lat;
                    blank_h  <= (scratch[11:8] == 4'd0);
                    blank_t  <= (scratch[11:8] == 4'd0) && (scratch[7:4] == 4'd0);
                    done     <= 1'b1;
                    valid    <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: WIDTH=9 and WIDTH=4 instances,
// expected digits computed arithmetically when each start is issued.
module tb_result_bcd_converter;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    logic       start9, sign9;
    logic [8:0] mag9;
    logic       busy9, done9, valid9, sgn9, bh9, bt9;
    logic [3:0] h9, t9, o9;

    logic       start4, sign4;
    logic [3:0] mag4;
    logic       busy4, done4, valid4, sgn4, bh4, bt4;
    logic [3:0] h4, t4, o4;

    result_bcd_converter #(.WIDTH(9)) dut (
        .clk(clk), .nrst(nrst), .start(start9), .mag(mag9), .sign_in(sign9),
        .busy(busy9), .done(done9), .valid(valid9), .sign_out(sgn9),
        .hundreds(h9), .tens(t9), .ones(o9), .blank_h(bh9), .blank_t(bt9)
    );

    result_bcd_converter #(.WIDTH(4)) dut4 (
        .clk(clk), .nrst(nrst), .start(start4), .mag(mag4), .sign_in(sign4),
        .busy(busy4), .done(done4), .valid(valid4), .sign_out(sgn4),
        .hundreds(h4), .tens(t4), .ones(o4), .blank_h(bh4), .blank_t(bt4)
    );

    bit         sel4;
    logic       obs_busy, obs_done, obs_valid, obs_sign, obs_bh, obs_bt;
    logic [3:0] obs_h, obs_t, obs_o;
    assign obs_busy  = sel4 ? busy4  : busy9;
    assign obs_done  = sel4 ? done4  : done9;
    assign obs_valid = sel4 ? valid4 : valid9;
    assign obs_sign  = sel4 ? sgn4   : sgn9;
    assign obs_bh    = sel4 ? bh4    : bh9;
    assign obs_bt    = sel4 ? bt4    : bt9;
    assign obs_h     = sel4 ? h4     : h9;
    assign obs_t     = sel4 ? t4     : t9;
    assign obs_o     = sel4 ? o4     : o9;

    typedef struct {
        logic [3:0] h, t, o;
        logic       s, bh, bt;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] last_h = 4'd0, last_t = 4'd0, last_o = 4'd0;

    function automatic exp_t model(input int m, input bit s);
        exp_t e;
        e.h  = 4'(m / 100);
        e.t  = 4'((m / 10) % 10);
        e.o  = 4'(m % 10);
        e.s  = s && (m != 0);
        e.bh = (m < 100);
        e.bt = (m < 10);
        return e;
    endfunction

    task automatic set_start(input bit st, input int m, input bit s);
        if (sel4) begin
            start4 = st; mag4 = 4'(m); sign4 = s;
        end else begin
            start9 = st; mag9 = 9'(m); sign9 = s;
        end
    endtask

    // Issues one start, waits for done (bounded), pops the scoreboard and compares.
    // inj_* name cycles (edge numbers after the start edge) on which a stray start is driven.
    task automatic convert(input int m, input bit s, input int exp_lat,
                           input int inj_a, input int inj_b, input int inj_c);
        exp_t e;
        int   n, busy_n, extra_done, extra_busy;
        bit   hold_ok;
        sb.push_back(model(m, s));
        @(negedge clk);
        set_start(1'b1, m, s);
        @(negedge clk);
        n = 1; busy_n = 0; hold_ok = 1'b1;
        set_start(1'b0, int'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
        while (!obs_done && n < 40) begin
            if (obs_busy) busy_n++;
            if ({obs_h, obs_t, obs_o} !== {last_h, last_t, last_o}) hold_ok = 1'b0;
            if (n == inj_a || n == inj_b || n == inj_c) set_start(1'b1, 9, 1'b0);
            else set_start(1'b0, 9, 1'b0);
            @(negedge clk);
            n++;
        end
        set_start(1'b0, 0, 1'b0);
        checks++;
        if (!obs_done) begin
            errors++;
            $display("FAIL done_timeout mag=%0d: no done within %0d cycles", m, n);
        end
        checks++;
        if ((n - 1) !== exp_lat) begin
            errors++;
            $display("FAIL latency mag=%0d: got %0d required %0d", m, n - 1, exp_lat);
        end
        checks++;
        if (busy_n !== exp_lat) begin
            errors++;
            $display("FAIL busy_cycles mag=%0d: got %0d required %0d", m, busy_n, exp_lat);
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL hold mag=%0d: digits changed before done, required %0d/%0d/%0d",
                     m, last_h, last_t, last_o);
        end
        e = sb.pop_front();
        checks++;
        if ({obs_h, obs_t, obs_o} !== {e.h, e.t, e.o}) begin
            errors++;
            $display("FAIL digits mag=%0d: got %0d/%0d/%0d required %0d/%0d/%0d",
                     m, obs_h, obs_t, obs_o, e.h, e.t, e.o);
        end
        checks++;
        if ({obs_sign, obs_bh, obs_bt, obs_valid} !== {e.s, e.bh, e.bt, 1'b1}) begin
            errors++;
            $display("FAIL flags mag=%0d: sign/bh/bt/valid got %b%b%b%b required %b%b%b1",
                     m, obs_sign, obs_bh, obs_bt, obs_valid, e.s, e.bh, e.bt);
        end
        last_h = e.h; last_t = e.t; last_o = e.o;
        extra_done = 0; extra_busy = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (obs_done) extra_done++;
            if (obs_busy) extra_busy++;
        end
        checks++;
        if (extra_done !== 0 || extra_busy !== 0) begin
            errors++;
            $display("FAIL after_done mag=%0d: extra done %0d busy %0d required 0/0",
                     m, extra_done, extra_busy);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        #12;
        checks++;
        if ({busy9, done9, valid9, sgn9, h9, t9, o9, bh9, bt9} !== 17'd0) begin
            errors++;
            $display("FAIL reset_state: got %h required 0",
                     {busy9, done9, valid9, sgn9, h9, t9, o9, bh9, bt9});
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_negative_zero();
        convert(0, 1'b1, 10, 0, 0, 0);
    endtask

    task automatic test_basic();
        convert(255, 1'b0, 10, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        convert(511, 1'b0, 10, 0, 0, 0);
        convert(7, 1'b1, 10, 0, 0, 0);
    endtask

    task automatic test_ignored_start();
        convert(100, 1'b0, 10, 3, 9, 10);
    endtask

    task automatic test_reset_abort();
        int dn;
        @(negedge clk);
        set_start(1'b1, 300, 1'b1);
        @(negedge clk);
        set_start(1'b0, 0, 1'b0);
        repeat (4) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({busy9, done9, valid9, sgn9, h9, t9, o9, bh9, bt9} !== 17'd0) begin
            errors++;
            $display("FAIL abort_reset: got %h required 0",
                     {busy9, done9, valid9, sgn9, h9, t9, o9, bh9, bt9});
        end
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done9 || busy9) dn++;
        end
        nrst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done9 || busy9 || valid9) dn++;
        end
        checks++;
        if (dn !== 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d active cycles required 0", dn);
        end
        last_h = 4'd0; last_t = 4'd0; last_o = 4'd0;
        convert(42, 1'b0, 10, 0, 0, 0);
    endtask

    task automatic test_width4();
        sel4 = 1'b1;
        last_h = 4'd0; last_t = 4'd0; last_o = 4'd0;
        convert(15, 1'b0, 5, 0, 0, 0);
        convert(9, 1'b1, 5, 0, 0, 0);
        sel4 = 1'b0;
    endtask

    initial begin
        sel4 = 1'b0;
        start9 = 1'b0; sign9 = 1'b0; mag9 = '0;
        start4 = 1'b0; sign4 = 1'b0; mag4 = '0;
        test_reset();
        test_negative_zero();
        test_basic();
        test_back_to_back();
        test_ignored_start();
        test_reset_abort();
        test_width4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
